regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 151 +++++++++++++++
 tb/tb_regfile_sb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with a per-register scoreboard.
//
// Purpose:
//   DEPTH = 2**ADDR_W registers of DATA_W bits, two combinational read ports and one
//   write port. The write data is chosen from mem_out, alu_out or pc+1. Every register
//   has a busy bit:
//   - an issue sets the busy bit;
//   - a write clears the busy bit;
//   - when both hit the same register in one cycle, the issue wins.
//   Register 0 always reads as zero and is never busy.
//
// Ports:
//   clk                 rising-edge clock for all state
//   rst_n               asynchronous active-low reset (registers, busy bits)
//   ra_addr / rb_addr   read-port A / B addresses
//   ra_data / rb_data   read-port A / B data (combinational)
//   ra_busy / rb_busy   busy flag of the register addressed on port A / B
//   we, wr_addr         write enable and write address
//   wb_sel              write source: 00 mem_out, 01 alu_out, 1x pc+1
//   mem_out, alu_out,
//   pc                  write-back sources
//   iss_valid, iss_addr issue strobe and destination register
//   stall               ra_busy | rb_busy
//   busy_cnt            number of busy registers
//
// Handshake semantics: iss_valid and we are single-cycle strobes with no ready.
// Each one is consumed at the rising edge where it is high and rst_n is 1.
// Nothing is ever back-pressured.
//
// Configuration:
//   RF_BYPASS_EN defined:
//     A read port whose address matches an in-flight write (we=1, wr_addr!=0) returns
//     the write data and reports busy=0 in the same cycle. stall follows.
//   RF_BYPASS_EN undefined:
//     Reads return stored contents only.

module regfile_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              ra_busy,
  output logic              rb_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wb_sel,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] pc,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              stall,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DATA_W-1:0] wb_data;
  logic              wr_hit;
  logic              iss_hit;

  // Address 0 is hard-wired, so writes and issues to it are dropped here.
  assign wr_hit  = we        && (wr_addr  != '0);
  assign iss_hit = iss_valid && (iss_addr != '0);

  // Write-back source mux. pc+1 wraps modulo 2**DATA_W by truncation.
  always_comb begin
    wb_data = '0;
    case (wb_sel)
      2'b00:   wb_data = mem_out;
      2'b01:   wb_data = alu_out;
      default: wb_data = pc + DATA_W'(1);
    endcase
  end

  // Register storage. Entry 0 is reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[wr_addr] <= wb_data;
    end
  end

  // Scoreboard next state.
  // The clear is applied first and the set second, so an issue to the register being
  // written in the same cycle leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_hit) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (iss_hit) begin
      busy_nxt[iss_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Population count of busy[DEPTH-1:1].
  // busy is zero during reset, so the count is zero there as well.
  always_comb begin
    busy_cnt = '0;
    for (int i = 1; i < DEPTH; i++) begin
      busy_cnt = busy_cnt + (ADDR_W + 1)'(busy[i]);
    end
  end

  // Read ports.
  logic              a_fwd;
  logic              b_fwd;
  logic [DATA_W-1:0] a_stored;
  logic [DATA_W-1:0] b_stored;

  assign a_stored = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign b_stored = (rb_addr == '0) ? '0 : regs[rb_addr];

`ifdef RF_BYPASS_EN
  // Forwarding is gated by rst_n so that outputs stay zero while reset is held,
  // even if a write strobe is present.
  assign a_fwd = rst_n && wr_hit && (ra_addr == wr_addr);
  assign b_fwd = rst_n && wr_hit && (rb_addr == wr_addr);
`else
  assign a_fwd = 1'b0;
  assign b_fwd = 1'b0;
`endif

  assign ra_data = a_fwd ? wb_data : a_stored;
  assign rb_data = b_fwd ? wb_data : b_stored;
  assign ra_busy = a_fwd ? 1'b0 : busy[ra_addr];
  assign rb_busy = b_fwd ? 1'b0 : busy[rb_addr];
  assign stall   = ra_busy | rb_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- self-checking bench for regfile_sb.
//
// Directed scenarios are followed by a randomized run. Each cycle's outputs are checked
// against a reference model: an array of register values plus a busy array.

`timescale 1ns/1ps

module tb_regfile_sb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  // Clock / reset.
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  // DUT signals.
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              ra_busy;
  logic              rb_busy;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wb_sel;
  logic [DATA_W-1:0] mem_out;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] pc;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              stall;
  logic [ADDR_W:0]   busy_cnt;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr   (ra_addr),
    .rb_addr   (rb_addr),
    .ra_data   (ra_data),
    .rb_data   (rb_data),
    .ra_busy   (ra_busy),
    .rb_busy   (rb_busy),
    .we        (we),
    .wr_addr   (wr_addr),
    .wb_sel    (wb_sel),
    .mem_out   (mem_out),
    .alu_out   (alu_out),
    .pc        (pc),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .stall     (stall),
    .busy_cnt  (busy_cnt)
  );

  // Reference model.
  int unsigned ref_val  [DEPTH];
  bit          ref_busy [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned model_wb();
    case (wb_sel)
      2'b00:   return int'(mem_out);
      2'b01:   return int'(alu_out);
      default: return (int'(pc) + 1) % (1 << DATA_W);
    endcase
  endfunction

  function automatic int unsigned model_count();
    int unsigned c = 0;
    for (int i = 1; i < DEPTH; i++) c += ref_busy[i];
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ref_val[i]  = 0;
      ref_busy[i] = 0;
    end
  endtask

  // Check the combinational outputs for the current inputs and model state.
  task automatic check_outputs();
    int unsigned ea;
    int unsigned eb;
    bit          eab;
    bit          ebb;
    ea  = (ra_addr == 0) ? 0 : ref_val[ra_addr];
    eb  = (rb_addr == 0) ? 0 : ref_val[rb_addr];
    eab = ref_busy[ra_addr];
    ebb = ref_busy[rb_addr];
`ifdef RF_BYPASS_EN
    if (rst_n && we && wr_addr != 0 && ra_addr == wr_addr) begin
      ea  = model_wb();
      eab = 0;
    end
    if (rst_n && we && wr_addr != 0 && rb_addr == wr_addr) begin
      eb  = model_wb();
      ebb = 0;
    end
`endif
    check("ra_data",  32'(ra_data),  ea);
    check("rb_data",  32'(rb_data),  eb);
    check("ra_busy",  32'(ra_busy),  32'(eab));
    check("rb_busy",  32'(rb_busy),  32'(ebb));
    check("stall",    32'(stall),    32'(eab | ebb));
    check("busy_cnt", 32'(busy_cnt), model_count());
  endtask

  // Driver: inputs are already set just after a negedge.
  // Checks run before the rising edge, then the model advances at that edge.
  task automatic do_cycle();
    #1;
    if (!rst_n) model_clear();  // reset acts immediately
    check_outputs();
    @(posedge clk);
    if (rst_n) begin
      if (we && wr_addr != 0) begin
        ref_val[wr_addr]  = model_wb();
        ref_busy[wr_addr] = 0;
      end
      if (iss_valid && iss_addr != 0) ref_busy[iss_addr] = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    we        = 0;
    iss_valid = 0;
    wr_addr   = 0;
    iss_addr  = 0;
    wb_sel    = 0;
    mem_out   = 0;
    alu_out   = 0;
    pc        = 0;
  endtask

  initial begin
    rst_n   = 0;
    ra_addr = 0;
    rb_addr = 0;
    idle();
    model_clear();
    @(negedge clk);
    do_cycle();                       // checks reset state
    rst_n = 1;

    // Write alu_out to r3, then read r3 back on port A.
    we = 1; wr_addr = 3; wb_sel = 2'b01; alu_out = 16'h1234;
    do_cycle();
    idle(); ra_addr = 3;
    do_cycle();
    check("r3_const", 32'(ra_data), 32'h1234);

    // A write to r0 is ignored.
    we = 1; wr_addr = 0; wb_sel = 2'b00; mem_out = 16'hBEEF;
    do_cycle();
    idle(); ra_addr = 0;
    do_cycle();
    check("r0_const",  32'(ra_data),  32'h0);
    check("cnt0_const", 32'(busy_cnt), 32'h0);

    // Issue r5, observe busy on port B, then write r5.
    iss_valid = 1; iss_addr = 5;
    do_cycle();
    idle(); rb_addr = 5;
    do_cycle();
    check("r5_busy_const", 32'(rb_busy), 32'h1);
    we = 1; wr_addr = 5; wb_sel = 2'b00; mem_out = 16'h5555;
    do_cycle();
    idle();
    do_cycle();
    check("r5_free_const", 32'(rb_busy), 32'h0);

    // Write and issue the same busy register in one cycle.
    iss_valid = 1; iss_addr = 2;
    do_cycle();
    idle();
    we = 1; wr_addr = 2; wb_sel = 2'b01; alu_out = 16'hA5A5;
    iss_valid = 1; iss_addr = 2; ra_addr = 2;
    do_cycle();
    idle();
    do_cycle();
    check("r2_data_const", 32'(ra_data), 32'hA5A5);
    check("r2_busy_const", 32'(ra_busy), 32'h1);

    // pc+1 wraps to zero.
    we = 1; wr_addr = 7; wb_sel = 2'b10; pc = 16'hFFFF; ra_addr = 7;
    do_cycle();
    idle();
    do_cycle();
    check("r7_wrap_const", 32'(ra_data), 32'h0);

    // Issue r1, r4 and r6, then pulse reset between edges.
    for (int k = 0; k < 3; k++) begin
      iss_valid = 1;
      iss_addr  = (k == 0) ? 3'd1 : (k == 1) ? 3'd4 : 3'd6;
      do_cycle();
    end
    idle();
    rst_n = 0;
    model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      ra_addr = ADDR_W'(a);
      #1;
      check("rst_read",  32'(ra_data),  32'h0);
      check("rst_cnt",   32'(busy_cnt), 32'h0);
      check("rst_stall", 32'(stall),    32'h0);
    end
    // A pending write and issue while reset is held are discarded.
    we = 1; wr_addr = 4; alu_out = 16'h7777; wb_sel = 2'b01;
    iss_valid = 1; iss_addr = 4;
    @(negedge clk);
    do_cycle();
    rst_n = 1;
    // The first write after release takes effect at the first edge.
    idle(); ra_addr = 4;
    we = 1; wr_addr = 4; wb_sel = 2'b00; mem_out = 16'h0F0F;
    do_cycle();
    idle();
    do_cycle();
    check("post_rst_const", 32'(ra_data), 32'h0F0F);

    // Randomized run.
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      we        = $urandom_range(0, 1);
      iss_valid = ($urandom_range(0, 2) != 0);
      wr_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
      iss_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      ra_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      rb_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
      wb_sel    = 2'($urandom_range(0, 3));
      mem_out   = DATA_W'($urandom);
      alu_out   = DATA_W'($urandom);
      pc        = ($urandom_range(0, 7) == 0) ? {DATA_W{1'b1}} : DATA_W'($urandom);
      do_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
